// File: rtl/calc_inst_sequencer.sv
// calc_inst_sequencer: buffers 8-bit calculator instructions in a small FIFO,
// executes PUSH/ADD/MULT against an external 4x8 register file and streams
// SEND results to the UART as uppercase ASCII hex.
// Optional build macro: SEND_CRLF_EN -- when defined, every SEND is followed
// by a CR/LF byte pair; when undefined, SEND emits only the two hex digits.
module calc_inst_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inst_vld,
  input  logic [7:0] inst_wd,
  output logic       inst_rdy,
  output logic [1:0] rf_ra_addr,
  output logic [1:0] rf_rb_addr,
  input  logic [7:0] rf_ra_data,
  input  logic [7:0] rf_rb_data,
  output logic       rf_we,
  output logic [1:0] rf_wa,
  output logic [7:0] rf_wd,
  output logic       tx_vld,
  output logic [7:0] tx_data,
  input  logic       tx_rdy,
  output logic       busy,
  output logic       done,
  output logic [7:0] last_wd
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    S_HI = 3'd2,
    S_LO = 3'd3
`ifdef SEND_CRLF_EN
    ,
    S_CR = 3'd4,
    S_LF = 3'd5
`endif
  } state_t;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n <= 4'd9) begin
      return 8'h30 + {4'h0, n};
    end else begin
      return 8'h37 + {4'h0, n};
    end
  endfunction

  // Write-back value for the non-SEND opcodes (results wrap to 8 bits).
  function automatic logic [7:0] alu_result(input logic [1:0] op, input logic [3:0] imm,
                                            input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'h00, a} * {8'h00, b};
    case (op)
      OP_PUSH: return {4'h0, imm};
      OP_ADD:  return a + b;
      OP_MULT: return prod[7:0];
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [7:0]    ir_q, ir_d, sr_q, sr_d;
  logic          rf_we_q, rf_we_d, done_q, done_d, tx_vld_q, tx_vld_d;
  logic [1:0]    rf_wa_q, rf_wa_d;
  logic [7:0]    rf_wd_q, rf_wd_d, tx_data_q, tx_data_d, last_wd_q, last_wd_d;
  logic          push_s, pop_s, hs_s, send_done_s;
  logic [7:0]    head_s;

  assign inst_rdy = (cnt_q != FULL_CNT);
  assign push_s   = inst_vld & inst_rdy;
  assign pop_s    = (state_q == IDLE) && (cnt_q != CW'(0));
  assign head_s   = mem_q[rd_ptr_q];
  assign hs_s     = tx_vld_q & tx_rdy;

  assign rf_we   = rf_we_q;
  assign rf_wa   = rf_wa_q;
  assign rf_wd   = rf_wd_q;
  assign tx_vld  = tx_vld_q;
  assign tx_data = tx_data_q;
  assign last_wd = last_wd_q;
  assign done    = done_q | send_done_s;
  assign busy    = (state_q != IDLE) || (cnt_q != CW'(0));

  // FIFO storage, pointers and occupancy; push and pop may coincide.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_s) begin
      mem_d[wr_ptr_q] = inst_wd;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Register-file read addresses: the FIFO head while waiting (operands are
  // fetched at pop time), the latched instruction during EXEC.
  always_comb begin
    if (state_q == EXEC) begin
      rf_ra_addr = (ir_q[7:6] == OP_SEND) ? ir_q[5:4] : ir_q[3:2];
      rf_rb_addr = ir_q[1:0];
    end else begin
      rf_ra_addr = head_s[3:2];
      rf_rb_addr = head_s[1:0];
    end
  end

  // Sequencer next-state and output computation.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    sr_d        = sr_q;
    rf_we_d     = 1'b0;
    rf_wa_d     = rf_wa_q;
    rf_wd_d     = rf_wd_q;
    done_d      = 1'b0;
    tx_vld_d    = tx_vld_q;
    tx_data_d   = tx_data_q;
    last_wd_d   = last_wd_q;
    send_done_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          ir_d    = head_s;
          state_d = EXEC;
          if (head_s[7:6] != OP_SEND) begin
            // Result is registered so the write appears during EXEC.
            rf_we_d = 1'b1;
            rf_wa_d = head_s[5:4];
            rf_wd_d = alu_result(head_s[7:6], head_s[3:0], rf_ra_data, rf_rb_data);
            done_d  = 1'b1;
          end else begin
            rf_we_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (ir_q[7:6] == OP_SEND) begin
          sr_d      = rf_ra_data;
          last_wd_d = rf_ra_data;
          tx_vld_d  = 1'b1;
          tx_data_d = hex_ascii(rf_ra_data[7:4]);
          state_d   = S_HI;
        end else begin
          last_wd_d = rf_wd_q;
          state_d   = IDLE;
        end
      end
      S_HI: begin
        if (hs_s) begin
          tx_data_d = hex_ascii(sr_q[3:0]);
          state_d   = S_LO;
        end else begin
          state_d = S_HI;
        end
      end
      S_LO: begin
        if (hs_s) begin
`ifdef SEND_CRLF_EN
          tx_data_d = 8'h0D;
          state_d   = S_CR;
`else
          tx_vld_d    = 1'b0;
          send_done_s = 1'b1;
          state_d     = IDLE;
`endif
        end else begin
          state_d = S_LO;
        end
      end
`ifdef SEND_CRLF_EN
      S_CR: begin
        if (hs_s) begin
          tx_data_d = 8'h0A;
          state_d   = S_LF;
        end else begin
          state_d = S_CR;
        end
      end
      S_LF: begin
        if (hs_s) begin
          tx_vld_d    = 1'b0;
          send_done_s = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = S_LF;
        end
      end
`endif
      default: begin
        tx_vld_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything except the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q  <= AW'(0);
      rd_ptr_q  <= AW'(0);
      cnt_q     <= CW'(0);
      state_q   <= IDLE;
      ir_q      <= 8'h00;
      sr_q      <= 8'h00;
      rf_we_q   <= 1'b0;
      rf_wa_q   <= 2'b00;
      rf_wd_q   <= 8'h00;
      done_q    <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= 8'h00;
      last_wd_q <= 8'h00;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      ir_q      <= ir_d;
      sr_q      <= sr_d;
      rf_we_q   <= rf_we_d;
      rf_wa_q   <= rf_wa_d;
      rf_wd_q   <= rf_wd_d;
      done_q    <= done_d;
      tx_vld_q  <= tx_vld_d;
      tx_data_q <= tx_data_d;
      last_wd_q <= last_wd_d;
    end
  end

endmodule
